word_split_serial: RTL and testbench
====================================

WORD_SPLIT_SERIAL -- requirements
Module: word_split_serial

Interface
REQ-001 Parameter WIDTH, default 16: input word width in bits.
REQ-002 Parameter NCHUNK, default 4: chunks per word; WIDTH % NCHUNK == 0, NCHUNK >= 1; CHUNK = WIDTH/NCHUNK; IW = max(1, $clog2(NCHUNK)).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_val  input  1  upstream word valid.
REQ-006 in_rdy  output  1  block can accept a word this cycle.
REQ-007 in_msg  input  WIDTH  word to split.
REQ-008 in_msb_first  input  1  order for this word: 0 = low chunk first, 1 = high chunk first; sampled with the word.
REQ-009 out_val  output  1  chunk valid.
REQ-010 out_rdy  input  1  downstream accepts chunk.
REQ-011 out_msg  output  CHUNK  current chunk.
REQ-012 out_idx  output  IW  bit-slice index of out_msg: out_msg == word[out_idx*CHUNK +: CHUNK].
REQ-013 out_last  output  1  current chunk is the final chunk of its word.

Function
REQ-014 Word transfer occurs when in_val & in_rdy; chunk transfer occurs when out_val & out_rdy.
REQ-015 States: IDLE (no word held) and BUSY (word held, chunks pending).
REQ-016 IDLE: in_rdy=1, out_val=0; on word transfer, register in_msg and in_msb_first, go BUSY.
REQ-017 Latency: the first chunk of a word accepted at edge t is presented on out_* in the cycle after edge t; no combinational in-to-out path.
REQ-018 Chunk order: lsb-first emits idx 0,1,..,NCHUNK-1; msb-first emits NCHUNK-1,..,0.
REQ-019 out_last=1 exactly on idx NCHUNK-1 (lsb-first) or idx 0 (msb-first), and only while out_val=1.
REQ-020 BUSY: on chunk transfer of a non-last chunk, advance to the next index; while out_val & !out_rdy, out_msg/out_idx/out_last are held stable.
REQ-021 BUSY: in_rdy = out_rdy & out_last (back-to-back); on last-chunk transfer with simultaneous word transfer, load new word and stay BUSY, so the first new chunk follows the last old chunk with zero bubble.
REQ-022 BUSY: on last-chunk transfer without word transfer, go IDLE.
REQ-023 Throughput: one chunk per cycle under continuous out_rdy=1 and in_val=1.
REQ-024 NCHUNK=1: every chunk is last; out_msg = whole word; sustained one word per cycle.
REQ-025 in_msg/in_msb_first changes while not transferred have no effect.
REQ-026 out_msg in IDLE is don't-care; bench checks it only when out_val=1.

Reset
REQ-027 reset_n=0 forces IDLE, out_val=0, out_last=0, index=0 immediately, independent of clk.
REQ-028 Reset mid-word discards the held word and remaining chunks; no chunk of it is emitted after reset.
REQ-029 First word transfer possible on the first rising edge with reset_n=1.
REQ-030 Data register need not be reset.

Structure
REQ-031 Package word_split_pkg holds the state enum (IDLE, BUSY).
REQ-032 Sub-module word_split_idx_ctr: up/down index counter with load (start index from order), enable, and last flag.
REQ-033 Datapath: one WIDTH-bit word register, one order bit, indexed chunk mux.

Verification
REQ-034 Defaults, word 0xABCD lsb-first, out_rdy=1 -> chunks D,C,B,A, idx 0..3, out_last only on A.
REQ-035 Word 0xABCD msb-first -> chunks A,B,C,D, idx 3..0, out_last on D.
REQ-036 Backpressure: out_rdy=0 for 3 cycles on chunk 1 of 0x1234 -> out_msg=3, idx=1 held stable, in_rdy=0; resume yields 2,1.
REQ-037 Back-to-back 0x1111 then 0x2222, in_val=1, out_rdy=1 -> 8 consecutive valid cycles, no bubble, in_rdy=1 only on last-chunk cycles.
REQ-038 reset_n low mid-word after chunk 1 of 0xABCD -> out_val=0 at once; after release, new word 0x5A5A emits A,5,A,5 only.
REQ-039 WIDTH=8, NCHUNK=1, words 0x12,0x34 consecutive -> out 0x12,0x34 on successive cycles, out_last=1 each.

Source files
------------

// File: rtl/word_split_pkg.sv
// Shared definitions for the word splitter.
//   state_e  : controller state (IDLE = no word held, BUSY = chunks pending)
//   idx_w()  : width of a chunk index for a given chunk count (at least 1 bit)
package word_split_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/word_split_idx_ctr.sv
// Chunk index counter for the word splitter.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   load_i         : start a new word; index jumps to its first chunk
//   msb_first_i    : order of the word being loaded (1 = count down)
//   en_i           : step to the next chunk in the stored order
//   idx_o          : current chunk index
//   last_o         : current index is the final chunk for the stored order
module word_split_idx_ctr #(
   parameter int NCHUNK = 4,
   parameter int IW     = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load_i,
   input  logic          msb_first_i,
   input  logic          en_i,
   output logic [IW-1:0] idx_o,
   output logic          last_o
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   logic [IW-1:0] idx_q, idx_d;
   logic          dir_q, dir_d;

   always_comb begin
      idx_d = idx_q;
      dir_d = dir_q;
      if (load_i) begin
         dir_d = msb_first_i;
         idx_d = msb_first_i ? LAST_IDX : '0;
      end else if (en_i) begin
         idx_d = dir_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q <= '0;
         dir_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         dir_q <= dir_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);

endmodule

// File: rtl/word_split_serial.sv
// Splits a WIDTH-bit word into NCHUNK chunks emitted one per handshake,
// low chunk first or high chunk first as chosen with each word.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_val/in_rdy/in_msg    : word input handshake and data
//   in_msb_first            : order for the word being accepted
//   out_val/out_rdy/out_msg : chunk output handshake and data
//   out_idx                 : slice index of out_msg within the held word
//   out_last                : out_msg is the final chunk of its word
module word_split_serial
   import word_split_pkg::*;
#(
   parameter int  WIDTH  = 16,
   parameter int  NCHUNK = 4,
   localparam int CHUNK  = WIDTH / NCHUNK,
   localparam int IW     = idx_w(NCHUNK)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_msg,
   input  logic             in_msb_first,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [CHUNK-1:0] out_msg,
   output logic [IW-1:0]    out_idx,
   output logic             out_last
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] word_q;
   logic             ctr_last;
   logic             word_xfer;
   logic             chunk_xfer;
   logic             ctr_en;

   assign word_xfer  = in_val & in_rdy;
   assign chunk_xfer = out_val & out_rdy;
   // The last chunk never advances the index; a following load sets it instead.
   assign ctr_en     = chunk_xfer & ~out_last;

   word_split_idx_ctr #(
      .NCHUNK (NCHUNK),
      .IW     (IW)
   ) u_idx_ctr (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (word_xfer),
      .msb_first_i (in_msb_first),
      .en_i        (ctr_en),
      .idx_o       (out_idx),
      .last_o      (ctr_last)
   );

   always_comb begin
      state_d  = state_q;
      in_rdy   = 1'b0;
      out_val  = 1'b0;
      out_last = 1'b0;
      case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_val) state_d = BUSY;
         end
         BUSY: begin
            out_val  = 1'b1;
            out_last = ctr_last;
            // Accept the next word in the same cycle the last chunk leaves.
            in_rdy   = out_rdy & ctr_last;
            if (out_rdy && ctr_last && !in_val) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Data holds no meaning outside BUSY, so it carries no reset.
   always_ff @(posedge clk) begin
      if (word_xfer) word_q <= in_msg;
   end

   always_comb begin
      out_msg = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (out_idx == IW'(i)) out_msg = word_q[i*CHUNK +: CHUNK];
      end
   end

endmodule

// File: tb/tb_word_split_serial.sv
module tb_word_split_serial;

   logic        clk;
   logic        reset_n;

   // 16-bit / 4-chunk instance
   logic        in_val, in_rdy, in_msb_first, out_val, out_rdy, out_last;
   logic [15:0] in_msg;
   logic [3:0]  out_msg;
   logic [1:0]  out_idx;

   // 8-bit / 1-chunk instance
   logic        b_in_val, b_in_rdy, b_out_val, b_out_rdy, b_out_last;
   logic [7:0]  b_in_msg, b_out_msg;
   logic [0:0]  b_out_idx;

   int n_total = 0;
   int n_pass  = 0;

   word_split_serial #(.WIDTH(16), .NCHUNK(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_val       (in_val),
      .in_rdy       (in_rdy),
      .in_msg       (in_msg),
      .in_msb_first (in_msb_first),
      .out_val      (out_val),
      .out_rdy      (out_rdy),
      .out_msg      (out_msg),
      .out_idx      (out_idx),
      .out_last     (out_last)
   );

   word_split_serial #(.WIDTH(8), .NCHUNK(1)) dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_val       (b_in_val),
      .in_rdy       (b_in_rdy),
      .in_msg       (b_in_msg),
      .in_msb_first (1'b0),
      .out_val      (b_out_val),
      .out_rdy      (b_out_rdy),
      .out_msg      (b_out_msg),
      .out_idx      (b_out_idx),
      .out_last     (b_out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Emission k of a word: expected chunk in chunks[k*4 +: 4], index in idxs[k*2 +: 2].
   typedef struct {
      logic [15:0] msg;
      logic        msb;
      logic [15:0] chunks;
      logic [7:0]  idxs;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Starts from IDLE with the clock away from its rising edge.
   task automatic run_vec(input int v);
      in_val       = 1'b1;
      in_msg       = vecs[v].msg;
      in_msb_first = vecs[v].msb;
      out_rdy      = 1'b1;
      @(posedge clk); #1;
      in_val       = 1'b0;
      in_msg       = 16'h0000;
      in_msb_first = ~vecs[v].msb;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d_val%0d", v, k),  32'(out_val),  32'd1);
         chk($sformatf("v%0d_msg%0d", v, k),  32'(out_msg),  32'(vecs[v].chunks[k*4 +: 4]));
         chk($sformatf("v%0d_idx%0d", v, k),  32'(out_idx),  32'(vecs[v].idxs[k*2 +: 2]));
         chk($sformatf("v%0d_last%0d", v, k), 32'(out_last), 32'(k == 3));
         chk($sformatf("v%0d_rdy%0d", v, k),  32'(in_rdy),   32'(k == 3));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_val", v),  32'(out_val),  32'd0);
      chk($sformatf("v%0d_idle_last", v), 32'(out_last), 32'd0);
   endtask

   initial begin
      vecs[0] = '{msg: 16'hABCD, msb: 1'b0, chunks: 16'hABCD, idxs: 8'hE4}; // D,C,B,A idx 0..3
      vecs[1] = '{msg: 16'hABCD, msb: 1'b1, chunks: 16'hDCBA, idxs: 8'h1B}; // A,B,C,D idx 3..0
      vecs[2] = '{msg: 16'h1234, msb: 1'b1, chunks: 16'h4321, idxs: 8'h1B}; // 1,2,3,4 idx 3..0
      vecs[3] = '{msg: 16'h5A5A, msb: 1'b0, chunks: 16'h5A5A, idxs: 8'hE4}; // A,5,A,5 idx 0..3

      reset_n = 1'b0;
      in_val = 1'b0; in_msg = 16'h0; in_msb_first = 1'b0; out_rdy = 1'b1;
      b_in_val = 1'b0; b_in_msg = 8'h0; b_out_rdy = 1'b1;

      #1;
      chk("rst_val",  32'(out_val),  32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_idx",  32'(out_idx),  32'd0);
      chk("rst_rdy",  32'(in_rdy),   32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven words
      for (int v = 0; v < 4; v++) run_vec(v);

      // Backpressure on chunk 1 of 0x1234 lsb-first
      in_val = 1'b1; in_msg = 16'h1234; in_msb_first = 1'b0; out_rdy = 1'b1;
      @(posedge clk); #1;
      in_val = 1'b0;
      @(negedge clk);
      chk("bp_c0_msg", 32'(out_msg), 32'h4);
      @(posedge clk); #1;
      out_rdy = 1'b0;
      in_val = 1'b1; in_msg = 16'hFFFF; in_msb_first = 1'b1;   // not accepted, must not matter
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_val%0d", k),  32'(out_val),  32'd1);
         chk($sformatf("bp_hold_msg%0d", k),  32'(out_msg),  32'h3);
         chk($sformatf("bp_hold_idx%0d", k),  32'(out_idx),  32'd1);
         chk($sformatf("bp_hold_last%0d", k), 32'(out_last), 32'd0);
         chk($sformatf("bp_hold_rdy%0d", k),  32'(in_rdy),   32'd0);
         @(posedge clk); #1;
      end
      out_rdy = 1'b1; in_val = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("bp_res_msg%0d", k),  32'(out_msg),  32'(4 - k));
         chk($sformatf("bp_res_idx%0d", k),  32'(out_idx),  32'(k));
         chk($sformatf("bp_res_last%0d", k), 32'(out_last), 32'(k == 3));
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("bp_end_val", 32'(out_val), 32'd0);

      // Back-to-back words, no bubble
      in_val = 1'b1; in_msg = 16'h1111; in_msb_first = 1'b0; out_rdy = 1'b1;
      @(posedge clk); #1;
      in_msg = 16'h2222;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_val%0d", k),  32'(out_val),  32'd1);
         chk($sformatf("b2b_msg%0d", k),  32'(out_msg),  (k < 4) ? 32'h1 : 32'h2);
         chk($sformatf("b2b_idx%0d", k),  32'(out_idx),  32'(k % 4));
         chk($sformatf("b2b_rdy%0d", k),  32'(in_rdy),   32'((k % 4) == 3));
         chk($sformatf("b2b_last%0d", k), 32'(out_last), 32'((k % 4) == 3));
         @(posedge clk); #1;
         if (k == 3) in_val = 1'b0;
      end
      @(negedge clk);
      chk("b2b_end_val", 32'(out_val), 32'd0);

      // Reset in the middle of 0xABCD
      in_val = 1'b1; in_msg = 16'hABCD; in_msb_first = 1'b0; out_rdy = 1'b1;
      @(posedge clk); #1;
      in_val = 1'b0;
      @(negedge clk);
      chk("mrst_c0_msg", 32'(out_msg), 32'hD);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst_c1_msg", 32'(out_msg), 32'hC);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_val",  32'(out_val),  32'd0);
      chk("mrst_last", 32'(out_last), 32'd0);
      chk("mrst_idx",  32'(out_idx),  32'd0);
      chk("mrst_rdy",  32'(in_rdy),   32'd1);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("mrst_post_val", 32'(out_val), 32'd0);
      run_vec(3);

      // Single-chunk instance, consecutive words
      b_in_val = 1'b1; b_in_msg = 8'h12;
      @(posedge clk); #1;
      b_in_msg = 8'h34;
      @(negedge clk);
      chk("n1_val0",  32'(b_out_val),  32'd1);
      chk("n1_msg0",  32'(b_out_msg),  32'h12);
      chk("n1_last0", 32'(b_out_last), 32'd1);
      chk("n1_rdy0",  32'(b_in_rdy),   32'd1);
      @(posedge clk); #1;
      b_in_val = 1'b0;
      @(negedge clk);
      chk("n1_val1",  32'(b_out_val),  32'd1);
      chk("n1_msg1",  32'(b_out_msg),  32'h34);
      chk("n1_last1", 32'(b_out_last), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n1_end_val", 32'(b_out_val), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
